// File: rtl/aes_mixcol_pkg.sv
// -----------------------------------------------------------------------------
// aes_mixcol_pkg
//   Shared constants, FSM encoding and GF(2^8) helper for the AES MixColumns
//   engine. Holds the values otherwise found in the IP-wide defines:
//   byte width, state/column widths, the GF reduction constant and the FSM
//   state encodings (IDLE=0, RUN=1, DONE=2).
// -----------------------------------------------------------------------------
package aes_mixcol_pkg;

    localparam int MIXCOLUMN_WIDTH = 8;
    localparam int AES_STATE_W     = 128;
    localparam int AES_COL_W       = 32;

    // Low byte of the AES field polynomial x^8+x^4+x^3+x+1 (0x11B)
    localparam logic [7:0] GF_RED = 8'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mixcol_state_e;

    // Multiply a field element by x, reducing modulo the AES polynomial
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? GF_RED : 8'h00);
    endfunction

endpackage

// File: rtl/aes_mixcol_column.sv
// -----------------------------------------------------------------------------
// aes_mixcol_column
//   Combinational transform of one 32-bit AES column.
//   Ports:
//     col  in  32  column, row 0 byte in bits [31:24]
//     inv  in  1   0 = MixColumns [2 3 1 1], 1 = InvMixColumns [e b d 9]
//     res  out 32  transformed column, same byte layout
//   Every constant product is built from one xtime chain per byte
//   (x2, x4, x8) plus XORs; there are no lookup tables or multipliers.
// -----------------------------------------------------------------------------
module aes_mixcol_column
    import aes_mixcol_pkg::*;
(
    input  logic [AES_COL_W-1:0] col,
    input  logic                 inv,
    output logic [AES_COL_W-1:0] res
);

    logic [MIXCOLUMN_WIDTH-1:0] a_s  [4];
    logic [MIXCOLUMN_WIDTH-1:0] x2_s [4];
    logic [MIXCOLUMN_WIDTH-1:0] x4_s [4];
    logic [MIXCOLUMN_WIDTH-1:0] x8_s [4];
    logic [MIXCOLUMN_WIDTH-1:0] m2_s [4];
    logic [MIXCOLUMN_WIDTH-1:0] m3_s [4];
    logic [MIXCOLUMN_WIDTH-1:0] m9_s [4];
    logic [MIXCOLUMN_WIDTH-1:0] mb_s [4];
    logic [MIXCOLUMN_WIDTH-1:0] md_s [4];
    logic [MIXCOLUMN_WIDTH-1:0] me_s [4];

    for (genvar r = 0; r < 4; r++) begin : g_byte
        assign a_s[r]  = col[AES_COL_W-1-MIXCOLUMN_WIDTH*r -: MIXCOLUMN_WIDTH];
        assign x2_s[r] = xtime(a_s[r]);
        assign x4_s[r] = xtime(x2_s[r]);
        assign x8_s[r] = xtime(x4_s[r]);

        // Constant products as XOR combinations of the shared powers of x
        assign m2_s[r] = x2_s[r];
        assign m3_s[r] = x2_s[r] ^ a_s[r];
        assign m9_s[r] = x8_s[r] ^ a_s[r];
        assign mb_s[r] = x8_s[r] ^ x2_s[r] ^ a_s[r];
        assign md_s[r] = x8_s[r] ^ x4_s[r] ^ a_s[r];
        assign me_s[r] = x8_s[r] ^ x4_s[r] ^ x2_s[r];
    end

    for (genvar r = 0; r < 4; r++) begin : g_row
        logic [MIXCOLUMN_WIDTH-1:0] fwd_s;
        logic [MIXCOLUMN_WIDTH-1:0] inv_s;

        // Row r uses the coefficient vector rotated right by r
        assign fwd_s = m2_s[r] ^ m3_s[(r+1)%4] ^ a_s[(r+2)%4]  ^ a_s[(r+3)%4];
        assign inv_s = me_s[r] ^ mb_s[(r+1)%4] ^ md_s[(r+2)%4] ^ m9_s[(r+3)%4];

        assign res[AES_COL_W-1-MIXCOLUMN_WIDTH*r -: MIXCOLUMN_WIDTH] = inv ? inv_s : fwd_s;
    end

endmodule

// File: rtl/aes_mixcol_engine.sv
// -----------------------------------------------------------------------------
// aes_mixcol_engine
//   Iterative AES MixColumns / InvMixColumns engine on a 128-bit state.
//   A block is latched on acceptance, then COLS_PER_CYCLE columns are
//   rewritten in place per clock for 4/COLS_PER_CYCLE cycles. The result is
//   held on out_data with out_valid until downstream takes it; a new block
//   may be accepted on that same edge.
//   Parameters:
//     COLS_PER_CYCLE  1,2,4 columns per clock (anything else fails elaboration)
//     DATA_W          state width, must be 128
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     in_valid/in_ready        input handshake
//     in_data [DATA_W]         state; column c = in_data[127-32c -: 32]
//     in_inv                   0 = forward, 1 = inverse transform
//     in_bypass                only when AES_MIXCOL_BYPASS_EN is defined:
//                              block passes through unchanged (same latency)
//     out_valid/out_ready      output handshake
//     out_data [DATA_W]        result, same byte layout as in_data
//     busy                     high while a block is in RUN or DONE
//   Build option: define AES_MIXCOL_BYPASS_EN to add the in_bypass port.
// -----------------------------------------------------------------------------
module aes_mixcol_engine
    import aes_mixcol_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1,
    parameter int DATA_W         = 128
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_inv,
`ifdef AES_MIXCOL_BYPASS_EN
    input  logic              in_bypass,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("aes_mixcol_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end
    if (DATA_W != AES_STATE_W) begin : g_bad_width
        $error("aes_mixcol_engine: DATA_W must be 128");
    end

    localparam int         N_CYC    = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] CNT_LAST = 2'(N_CYC - 1);
    // Truncates to 0 for four columns per cycle; cnt is then always 0,
    // so the group base stays correct.
    localparam logic [1:0] CPC_2B   = 2'(COLS_PER_CYCLE);

    mixcol_state_e        state_r;
    mixcol_state_e        state_nxt_s;
    logic [1:0]           cnt_r;
    logic [1:0]           cnt_nxt_s;
    logic                 out_valid_r;
    logic                 out_valid_nxt_s;
    logic                 load_s;
    logic                 step_s;
    logic                 inv_r;
    logic [1:0]           base_s;

    logic [AES_COL_W-1:0] in_cols_s   [4];
    logic [AES_COL_W-1:0] work_r      [4];
    logic [AES_COL_W-1:0] work_nxt_s  [4];

    logic [1:0]           col_idx_s   [COLS_PER_CYCLE];
    logic [AES_COL_W-1:0] col_in_s    [COLS_PER_CYCLE];
    logic [AES_COL_W-1:0] col_res_s   [COLS_PER_CYCLE];
    logic [AES_COL_W-1:0] col_out_s   [COLS_PER_CYCLE];

`ifdef AES_MIXCOL_BYPASS_EN
    logic                 bypass_r;
`endif

    // Column view of the input and output state vectors
    for (genvar c = 0; c < 4; c++) begin : g_pack
        assign in_cols_s[c] = in_data[DATA_W-1-AES_COL_W*c -: AES_COL_W];
        assign out_data[DATA_W-1-AES_COL_W*c -: AES_COL_W] = work_r[c];
    end

    // First column of the group handled this cycle: cnt * COLS_PER_CYCLE
    assign base_s = cnt_r * CPC_2B;

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
        assign col_idx_s[g] = base_s + 2'(g);
        assign col_in_s[g]  = work_r[col_idx_s[g]];

        aes_mixcol_column u_column (
            .col (col_in_s[g]),
            .inv (inv_r),
            .res (col_res_s[g])
        );

`ifdef AES_MIXCOL_BYPASS_EN
        assign col_out_s[g] = bypass_r ? col_in_s[g] : col_res_s[g];
`else
        assign col_out_s[g] = col_res_s[g];
`endif
    end

    // Work register image with the current group's columns replaced
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            work_nxt_s[c] = work_r[c];
        end
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            work_nxt_s[col_idx_s[g]] = col_out_s[g];
        end
    end

    // Next-state, counter and handshake decode
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        out_valid_nxt_s = out_valid_r;
        load_s          = 1'b0;
        step_s          = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = 2'd0;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                step_s = 1'b1;
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s     = ST_DONE;
                    cnt_nxt_s       = 2'd0;
                    out_valid_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + 2'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_nxt_s = 1'b0;
                    // Accepting the next block on the hand-off edge avoids an idle cycle
                    if (in_valid) begin
                        state_nxt_s = ST_RUN;
                        cnt_nxt_s   = 2'd0;
                        load_s      = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s     = ST_IDLE;
                cnt_nxt_s       = 2'd0;
                out_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // FSM state, group counter and output-valid register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 2'd0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            out_valid_r <= out_valid_nxt_s;
        end
    end

    // Work register and per-block mode latches
    always_ff @(posedge clk) begin
        if (rst) begin
            inv_r <= 1'b0;
            for (int c = 0; c < 4; c++) begin
                work_r[c] <= {AES_COL_W{1'b0}};
            end
        end else if (load_s) begin
            inv_r <= in_inv;
            for (int c = 0; c < 4; c++) begin
                work_r[c] <= in_cols_s[c];
            end
        end else if (step_s) begin
            for (int c = 0; c < 4; c++) begin
                work_r[c] <= work_nxt_s[c];
            end
        end else begin
            inv_r <= inv_r;
        end
    end

`ifdef AES_MIXCOL_BYPASS_EN
    // Bypass mode latch, captured together with the block
    always_ff @(posedge clk) begin
        if (rst) begin
            bypass_r <= 1'b0;
        end else if (load_s) begin
            bypass_r <= in_bypass;
        end else begin
            bypass_r <= bypass_r;
        end
    end
`endif

    assign in_ready  = (state_r == ST_IDLE) | ((state_r == ST_DONE) & out_ready);
    assign busy      = (state_r != ST_IDLE);
    assign out_valid = out_valid_r;

endmodule
